// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BRK_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_t;

  // Majority samples sit one tick either side of the mid-bit count.
  localparam int SMP_EARLY = -1;
  localparam int SMP_LATE  = 1;

  function automatic parity_mode_t decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit oversample counter and 2-of-3 majority voter.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_serial,
  input  logic os_tick,
  input  logic restart,
  output logic line,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_end,
  output logic falling_edge
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam logic [CW-1:0] C_EARLY = CW'(MID + SMP_EARLY);
  localparam logic [CW-1:0] C_MID   = CW'(MID);
  localparam logic [CW-1:0] C_LATE  = CW'(MID + SMP_LATE);
  localparam logic [CW-1:0] C_LAST  = CW'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s_early, s_mid;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
  end

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (os_tick) begin
      if (restart)             cnt <= '0;
      else if (cnt == C_LAST)  cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      if (cnt == C_EARLY) s_early <= line;
      if (cnt == C_MID)   s_mid   <= line;
    end
  end

  // Third sample is the live line, so the vote resolves on the late tick.
  assign bit_valid    = os_tick && (cnt == C_LATE);
  assign bit_value    = (s_early & s_mid) | (s_early & line) | (s_mid & line);
  assign bit_end      = os_tick && (cnt == C_LAST);
  assign falling_edge = os_tick && !line;

endmodule

// File: rtl/uart_rx_core.sv
// Frame FSM, shift register, parity/stop/break checks and output holding register.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  input  logic              os_tick,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_parity_err,
  output logic              m_frame_err,
  output logic              m_break,
  output logic              overrun,
  output logic              busy
);

  localparam int BCW = $clog2(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  rx_state_t    state;
  parity_mode_t par_mode;
  logic              stop2_q, par_bit, ferr;
  logic [DATA_W-1:0] shreg;
  logic [BCW-1:0]    bit_cnt;

  logic line, bit_valid, bit_value, bit_end, start_cand, restart;
  logic par_x, par_err, brk_cond, complete, cmp_fe, cmp_brk;

  assign restart = (state == S_IDLE) && start_cand;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .rx_serial   (rx_serial),
    .os_tick     (os_tick),
    .restart     (restart),
    .line        (line),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .bit_end     (bit_end),
    .falling_edge(start_cand)
  );

  // par_bit is cleared at start, so it only participates when parity is on.
  always_comb begin
    par_x    = (^shreg) ^ par_bit;
    par_err  = 1'b0;
    case (par_mode)
      PAR_EVEN: par_err = par_x;
      PAR_ODD:  par_err = ~par_x;
      default:  par_err = 1'b0;
    endcase
    brk_cond = (shreg == '0) && !par_bit && !bit_value;
    complete = 1'b0;
    cmp_fe   = 1'b0;
    cmp_brk  = 1'b0;
    if (bit_valid) begin
      if (state == S_STOP1 && (brk_cond || !stop2_q)) begin
        complete = 1'b1;
        cmp_fe   = !bit_value;
        cmp_brk  = brk_cond;
      end else if (state == S_STOP2) begin
        complete = 1'b1;
        cmp_fe   = ferr | !bit_value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      par_mode <= PAR_NONE;
      stop2_q  <= 1'b0;
      par_bit  <= 1'b0;
      ferr     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_cand) begin
            state    <= S_START;
            par_mode <= decode_parity(cfg_parity);
            stop2_q  <= cfg_stop2;
            par_bit  <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        S_START: begin
          if (bit_valid && bit_value) state <= S_IDLE;
          else if (bit_end) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_valid) shreg <= {bit_value, shreg[DATA_W-1:1]};
          if (bit_end) begin
            if (bit_cnt == LAST_BIT)
              state <= (par_mode == PAR_NONE) ? S_STOP1 : S_PARITY;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_valid) par_bit <= bit_value;
          if (bit_end)   state   <= S_STOP1;
        end
        S_STOP1: begin
          // Leave at mid-bit on the last stop bit so the next start edge is not missed.
          if (bit_valid) begin
            ferr <= !bit_value;
            if (brk_cond)      state <= S_BRK_WAIT;
            else if (!stop2_q) state <= S_IDLE;
          end else if (bit_end && stop2_q) begin
            state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (bit_valid) state <= S_IDLE;
        end
        S_BRK_WAIT: begin
          if (os_tick && line) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_break      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!m_valid || m_ready) begin
          m_data       <= shreg;
          m_parity_err <= par_err;
          m_frame_err  <= cmp_fe;
          m_break      <= cmp_brk;
          m_valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed and randomized frames on three receiver configurations, scored against a frame-level model.
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst, rx, os_tick, m_ready, cfg_stop2;
  logic [1:0] cfg_parity;
  int sel;

  always #5 clk = ~clk;

  logic rx_a, rx_b, rx_c;
  assign rx_a = (sel == 0) ? rx : 1'b1;
  assign rx_b = (sel == 1) ? rx : 1'b1;
  assign rx_c = (sel == 2) ? rx : 1'b1;

  logic [7:0] d_a; logic [4:0] d_b; logic [8:0] d_c;
  logic v_a, pe_a, fe_a, bk_a, ov_a, by_a;
  logic v_b, pe_b, fe_b, bk_b, ov_b, by_b;
  logic v_c, pe_c, fe_c, bk_c, ov_c, by_c;

  uart_rx_core #(.DATA_W(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .rx_serial(rx_a), .os_tick(os_tick),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .m_data(d_a), .m_valid(v_a), .m_ready(m_ready),
    .m_parity_err(pe_a), .m_frame_err(fe_a), .m_break(bk_a),
    .overrun(ov_a), .busy(by_a));

  uart_rx_core #(.DATA_W(5), .OVERSAMPLE(8), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .rx_serial(rx_b), .os_tick(os_tick),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .m_data(d_b), .m_valid(v_b), .m_ready(m_ready),
    .m_parity_err(pe_b), .m_frame_err(fe_b), .m_break(bk_b),
    .overrun(ov_b), .busy(by_b));

  uart_rx_core #(.DATA_W(9), .OVERSAMPLE(8), .SYNC_STAGES(3)) dut_c (
    .clk(clk), .rst(rst), .rx_serial(rx_c), .os_tick(os_tick),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .m_data(d_c), .m_valid(v_c), .m_ready(m_ready),
    .m_parity_err(pe_c), .m_frame_err(fe_c), .m_break(bk_c),
    .overrun(ov_c), .busy(by_c));

  logic [8:0] obs_data;
  logic obs_valid, obs_pe, obs_fe, obs_brk, obs_ovr, obs_busy;

  always_comb begin
    case (sel)
      1:       {obs_data, obs_valid, obs_pe, obs_fe, obs_brk, obs_ovr, obs_busy} =
                 {4'b0, d_b, v_b, pe_b, fe_b, bk_b, ov_b, by_b};
      2:       {obs_data, obs_valid, obs_pe, obs_fe, obs_brk, obs_ovr, obs_busy} =
                 {d_c, v_c, pe_c, fe_c, bk_c, ov_c, by_c};
      default: {obs_data, obs_valid, obs_pe, obs_fe, obs_brk, obs_ovr, obs_busy} =
                 {1'b0, d_a, v_a, pe_a, fe_a, bk_a, ov_a, by_a};
    endcase
  end

  // Delivered frames as {break, frame_err, parity_err, data}.
  logic [11:0] rxq[$];
  int ovr_cnt = 0;
  always @(posedge clk) begin
    if (obs_valid && m_ready) rxq.push_back({obs_brk, obs_fe, obs_pe, obs_data});
    if (obs_ovr) ovr_cnt++;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One oversample period: line held for 4 clks, tick on the last one.
  task automatic slot(input logic v, input logic rdy);
    rx = v;
    repeat (3) step();
    os_tick = 1'b1;
    if (rdy) m_ready = 1'b1;
    step();
    os_tick = 1'b0;
    if (rdy) m_ready = 1'b0;
  endtask

  function automatic logic [11:0] model(input int dw, input logic [8:0] data, input logic [1:0] cp,
                                         input logic pbit, input logic st2, input logic s1, input logic s2);
    logic [8:0] d;
    logic en, odd, pe, fe, brk;
    int ones;
    d    = data & 9'((1 << dw) - 1);
    en   = (cp == 2'b01) || (cp == 2'b10);
    odd  = (cp == 2'b10);
    ones = $countones(d) + int'(pbit);
    pe   = en && ((ones % 2) != int'(odd));
    brk  = (d == 0) && (!en || !pbit) && !s1;
    fe   = brk || !s1 || (st2 && !s2);
    return {brk, fe, pe, brk ? 9'd0 : d};
  endfunction

  task automatic send_frame(input int os, input int dw, input logic [8:0] data, input logic [1:0] cp,
                            input logic st2, input logic pbit, input logic s1, input logic s2,
                            input int flip, input bit chk_lat, input bit rdy_dec);
    logic b[$];
    logic en, v;
    int dec;
    cfg_parity = cp;
    cfg_stop2  = st2;
    en = (cp == 2'b01) || (cp == 2'b10);
    b.push_back(1'b0);
    for (int i = 0; i < dw; i++) b.push_back(data[i]);
    if (en) b.push_back(pbit);
    b.push_back(s1);
    if (st2) b.push_back(s2);
    // First low slot is count 0; the stop-1 vote lands two slots past its mid-point.
    dec = (1 + dw + (en ? 1 : 0)) * os + os / 2 + 2;
    for (int k = 0; k < b.size() * os; k++) begin
      v = b[k / os];
      if (k == flip) v = ~v;
      if (k == os) begin
        cfg_parity = 2'($urandom_range(3));
        cfg_stop2  = 1'($urandom_range(1));
      end
      slot(v, rdy_dec && (k == dec));
      if (chk_lat && k == dec - 1) check("latency_before", obs_valid, 1'b0);
      if (chk_lat && k == dec)     check("latency_after", obs_valid, 1'b1);
    end
    for (int k = 0; k < 2 * os; k++) slot(1'b1, 1'b0);
  endtask

  task automatic chk_frame(input string tag, input logic [11:0] exp);
    check({tag, "_count"}, rxq.size(), 1);
    if (rxq.size() > 0) check(tag, rxq.pop_front(), exp);
    rxq.delete();
  endtask

  initial begin
    int o0, os, dw;
    logic [8:0] d;
    logic [1:0] cp;
    logic st2, pb, s1, s2;
    rst = 1'b1; rx = 1'b1; os_tick = 1'b0; m_ready = 1'b1;
    cfg_parity = 2'b00; cfg_stop2 = 1'b0; sel = 0;
    repeat (3) step();
    check("reset_outputs", {obs_valid, obs_pe, obs_fe, obs_brk, obs_ovr, obs_busy, obs_data}, 0);
    rst = 1'b0;
    step();

    send_frame(16, 8, 9'h0A5, 2'b00, 0, 0, 1, 1, -1, 1, 0);
    chk_frame("basic_a5", model(8, 9'h0A5, 2'b00, 0, 0, 1, 1));

    send_frame(16, 8, 9'h003, 2'b01, 0, 0, 1, 1, -1, 0, 0);
    chk_frame("even_ok", model(8, 9'h003, 2'b01, 0, 0, 1, 1));
    send_frame(16, 8, 9'h003, 2'b01, 0, 1, 1, 1, -1, 0, 0);
    chk_frame("even_bad", model(8, 9'h003, 2'b01, 1, 0, 1, 1));
    send_frame(16, 8, 9'h007, 2'b10, 0, 0, 1, 1, -1, 0, 0);
    chk_frame("odd_ok", model(8, 9'h007, 2'b10, 0, 0, 1, 1));

    for (int k = 0; k < 4; k++) slot(1'b0, 1'b0);
    for (int k = 0; k < 48; k++) slot(1'b1, 1'b0);
    check("glitch_busy", obs_busy, 1'b0);
    check("glitch_no_frame", rxq.size(), 0);

    send_frame(16, 8, 9'h0A5, 2'b00, 0, 0, 1, 1, 3 * 16 + 9, 0, 0);
    chk_frame("flip_majority", model(8, 9'h0A5, 2'b00, 0, 0, 1, 1));

    send_frame(16, 8, 9'h03C, 2'b00, 1, 0, 1, 0, -1, 0, 0);
    chk_frame("stop2_low", model(8, 9'h03C, 2'b00, 0, 1, 1, 0));

    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int k = 0; k < 20 * 16; k++) slot(1'b0, 1'b0);
    check("break_hold_busy", obs_busy, 1'b1);
    for (int k = 0; k < 32; k++) slot(1'b1, 1'b0);
    check("break_release", obs_busy, 1'b0);
    chk_frame("break", 12'hC00);

    m_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(16, 8, 9'h011, 2'b00, 0, 0, 1, 1, -1, 0, 0);
    send_frame(16, 8, 9'h022, 2'b00, 0, 0, 1, 1, -1, 0, 0);
    check("bp_overrun_once", ovr_cnt - o0, 1);
    check("bp_held_data", obs_data, 9'h011);
    check("bp_held_valid", obs_valid, 1'b1);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    chk_frame("bp_accept", model(8, 9'h011, 2'b00, 0, 0, 1, 1));
    o0 = ovr_cnt;
    send_frame(16, 8, 9'h011, 2'b00, 0, 0, 1, 1, -1, 0, 0);
    send_frame(16, 8, 9'h022, 2'b00, 0, 0, 1, 1, -1, 0, 1);
    check("swap_no_overrun", ovr_cnt - o0, 0);
    check("swap_data", obs_data, 9'h022);
    check("swap_valid", obs_valid, 1'b1);
    chk_frame("swap_old", model(8, 9'h011, 2'b00, 0, 0, 1, 1));
    m_ready = 1'b1; step();
    chk_frame("swap_new", model(8, 9'h022, 2'b00, 0, 0, 1, 1));

    m_ready = 1'b0;
    send_frame(16, 8, 9'h05A, 2'b00, 0, 0, 1, 1, -1, 0, 0);
    d = 9'h0B6;
    for (int k = 0; k < 16; k++) slot(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) for (int k = 0; k < 16; k++) slot(d[i], 1'b0);
    for (int k = 0; k < 8; k++) slot(d[3], 1'b0);
    rst = 1'b1; rx = 1'b1;
    step(); step();
    check("reset_midframe", {obs_valid, obs_pe, obs_fe, obs_brk, obs_ovr, obs_busy, obs_data}, 0);
    rst = 1'b0; m_ready = 1'b1;
    step();
    rxq.delete();
    send_frame(16, 8, 9'h0C3, 2'b00, 0, 0, 1, 1, -1, 0, 0);
    chk_frame("after_reset", model(8, 9'h0C3, 2'b00, 0, 0, 1, 1));

    sel = 1; step();
    send_frame(8, 5, 9'h015, 2'b00, 0, 0, 1, 1, -1, 0, 0);
    chk_frame("w5_os8", model(5, 9'h015, 2'b00, 0, 0, 1, 1));
    sel = 2; step();
    send_frame(8, 9, 9'h1AB, 2'b00, 0, 0, 1, 1, -1, 0, 0);
    chk_frame("w9_os8", model(9, 9'h1AB, 2'b00, 0, 0, 1, 1));

    for (int n = 0; n < 15; n++) begin
      sel = n % 3;
      os  = (sel == 0) ? 16 : 8;
      dw  = (sel == 0) ? 8 : (sel == 1) ? 5 : 9;
      d   = 9'($urandom) & 9'((1 << dw) - 1);
      if (n == 7) d = 9'd0;
      cp  = 2'($urandom_range(3));
      st2 = 1'($urandom_range(1));
      pb  = 1'($urandom_range(1));
      s1  = ($urandom_range(5) != 0) && (n != 7);
      s2  = ($urandom_range(5) != 0);
      if (n == 7) pb = 1'b0;
      step();
      send_frame(os, dw, d, cp, st2, pb, s1, s2, -1, 0, 0);
      chk_frame($sformatf("rand_%0d", n), model(dw, d, cp, pb, st2, s1, s2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
